fwd_hazard_tracker: RTL and testbench

- Parametrised successor to the pipeline forwarding unit.
- Tracks the destinations of in-flight instructions internally, so callers no longer pass EX/MEM and MEM/WB fields.
- Registers per-operand forward selects for the instruction entering EX, detects load-use hazards with a configurable load-ready position, and raises a stall.
- Sits between decode and the EX-stage operand muxes; also keeps a saturating stall-cycle performance counter.

---
 rtl/fwd_hazard_tracker.sv | 113 +++++++++++
 tb/tb_fwd_hazard_tracker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_tracker.sv
// Forwarding and load-use hazard tracker: follows in-flight destinations, registers
// per-operand EX forward selects and raises a combinational stall on load-use hazards.
module fwd_hazard_tracker #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 2,
    parameter int LOAD_POS = 2,
    parameter int CNT_W    = 16,
    parameter int SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              freeze,
    input  logic              flush,
    input  logic              perf_clear,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [CNT_W-1:0]  stall_count
);

    logic [DEPTH-1:0]  tValid_q;
    logic [DEPTH-1:0]  tWrite_q;
    logic [DEPTH-1:0]  tLoad_q;
    logic [REG_AW-1:0] tRd_q [DEPTH];

    logic [SEL_W-1:0]  fwdA_q, fwdB_q;
    logic [SEL_W-1:0]  fwdA_d, fwdB_d;
    logic [CNT_W-1:0]  stallCount_q;

    logic [DEPTH-1:0]  matchA, matchB;
    logic              hazardA, hazardB;
    logic              hazard;
    logic              shiftValid;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            matchA[j] = tValid_q[j] & tWrite_q[j] & (tRd_q[j] != '0)
                        & (tRd_q[j] == id_rs) & (id_rs != '0);
            matchB[j] = tValid_q[j] & tWrite_q[j] & (tRd_q[j] != '0)
                        & (tRd_q[j] == id_rt) & (id_rt != '0);
        end
    end

    // Walk oldest to youngest so the youngest matching entry overwrites older ones.
    always_comb begin
        fwdA_d  = '0;
        fwdB_d  = '0;
        hazardA = 1'b0;
        hazardB = 1'b0;
        for (int j = DEPTH - 1; j >= 0; j--) begin
            if (matchA[j]) begin
                fwdA_d  = SEL_W'(j + 1);
                hazardA = tLoad_q[j] & ((j + 1) < LOAD_POS);
            end
            if (matchB[j]) begin
                fwdB_d  = SEL_W'(j + 1);
                hazardB = tLoad_q[j] & ((j + 1) < LOAD_POS);
            end
        end
    end

    assign hazard     = hazardA | hazardB;
    assign stall      = id_valid & hazard & ~flush;
    assign shiftValid = id_valid & ~flush & ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            tValid_q <= '0;
            tWrite_q <= '0;
            tLoad_q  <= '0;
            for (int j = 0; j < DEPTH; j++) begin
                tRd_q[j] <= '0;
            end
            fwdA_q <= '0;
            fwdB_q <= '0;
        end else if (!freeze) begin
            for (int j = 1; j < DEPTH; j++) begin
                tValid_q[j] <= tValid_q[j-1];
                tWrite_q[j] <= tWrite_q[j-1];
                tLoad_q[j]  <= tLoad_q[j-1];
                tRd_q[j]    <= tRd_q[j-1];
            end
            tValid_q[0] <= shiftValid;
            tWrite_q[0] <= id_regwrite;
            tLoad_q[0]  <= id_is_load;
            tRd_q[0]    <= id_rd;
            fwdA_q      <= shiftValid ? fwdA_d : '0;
            fwdB_q      <= shiftValid ? fwdB_d : '0;
        end
    end

    // Clearing wins over counting and still works while the pipeline is frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount_q <= '0;
        end else if (perf_clear) begin
            stallCount_q <= '0;
        end else if (!freeze && stall && (stallCount_q != {CNT_W{1'b1}})) begin
            stallCount_q <= stallCount_q + 1'b1;
        end
    end

    assign fwd_a       = fwdA_q;
    assign fwd_b       = fwdB_q;
    assign stall_count = stallCount_q;

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Directed bench for fwd_hazard_tracker: three instances share one stimulus stream
// (default, DEPTH=3/LOAD_POS=3, CNT_W=2) and each check looks at the relevant one.
module tb_fwd_hazard_tracker;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       id_regwrite, id_is_load;
    logic       freeze, flush, perf_clear;

    logic        stall,  stall3,  stallC;
    logic [1:0]  fwd_a,  fwd_b,   fwdA3, fwdB3, fwdAC, fwdBC;
    logic [15:0] stall_count, count3;
    logic [1:0]  countC;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    fwd_hazard_tracker dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .freeze(freeze), .flush(flush), .perf_clear(perf_clear),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_count(stall_count)
    );

    fwd_hazard_tracker #(.DEPTH(3), .LOAD_POS(3)) dut3 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .freeze(freeze), .flush(flush), .perf_clear(perf_clear),
        .stall(stall3), .fwd_a(fwdA3), .fwd_b(fwdB3), .stall_count(count3)
    );

    fwd_hazard_tracker #(.CNT_W(2)) dutc (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
        .freeze(freeze), .flush(flush), .perf_clear(perf_clear),
        .stall(stallC), .fwd_a(fwdAC), .fwd_b(fwdBC), .stall_count(countC)
    );

    task automatic checkOutput(input string tag, input int unsigned actual,
                               input int unsigned expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    // Drive one ID instruction mid-cycle, leaving time for the combinational stall to settle.
    task automatic applyStimulus(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic [4:0] rd, input logic wr, input logic ld);
        @(negedge clk);
        id_valid    = v;
        id_rs       = rs;
        id_rt       = rt;
        id_rd       = rd;
        id_regwrite = wr;
        id_is_load  = ld;
        #1;
    endtask

    task automatic clockEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1; freeze = 1'b0; flush = 1'b0; perf_clear = 1'b0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        clockEdge();
        clockEdge();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        doReset();
        checkOutput("reset_stall", stall, 0);
        checkOutput("reset_fwd_a", fwd_a, 0);
        checkOutput("reset_fwd_b", fwd_b, 0);
        checkOutput("reset_count", stall_count, 0);

        // ADD r3 ; SUB rs=r3
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 1, 0);
        checkOutput("add_stall", stall, 0);
        clockEdge();
        applyStimulus(1, 5'd3, 5'd4, 5'd6, 1, 0);
        checkOutput("sub_stall", stall, 0);
        clockEdge();
        checkOutput("sub_fwd_a", fwd_a, 1);
        checkOutput("sub_fwd_b", fwd_b, 0);

        // ADD r3 ; NOP ; OR rt=r3
        doReset();
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 1, 0); clockEdge();
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0); clockEdge();
        applyStimulus(1, 5'd7, 5'd3, 5'd8, 1, 0); clockEdge();
        checkOutput("or_gap1_fwd_b", fwd_b, 2);
        checkOutput("or_gap1_fwd_a", fwd_a, 0);

        // ADD r3 ; NOP ; NOP ; OR rt=r3 : producer has left the window
        doReset();
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 1, 0); clockEdge();
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0); clockEdge();
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0); clockEdge();
        applyStimulus(1, 5'd7, 5'd3, 5'd8, 1, 0); clockEdge();
        checkOutput("or_gap2_fwd_b", fwd_b, 0);

        // ADD r3 ; ADD r3 ; AND rs=rt=r3 : youngest wins
        doReset();
        applyStimulus(1, 5'd1, 5'd2, 5'd3, 1, 0); clockEdge();
        applyStimulus(1, 5'd4, 5'd5, 5'd3, 1, 0); clockEdge();
        applyStimulus(1, 5'd3, 5'd3, 5'd9, 1, 0); clockEdge();
        checkOutput("and_young_fwd_a", fwd_a, 1);
        checkOutput("and_young_fwd_b", fwd_b, 1);

        // Same with r0 everywhere : never forwarded
        doReset();
        applyStimulus(1, 5'd1, 5'd2, 5'd0, 1, 0); clockEdge();
        applyStimulus(1, 5'd4, 5'd5, 5'd0, 1, 0); clockEdge();
        applyStimulus(1, 5'd0, 5'd0, 5'd9, 1, 0); clockEdge();
        checkOutput("and_r0_fwd_a", fwd_a, 0);
        checkOutput("and_r0_fwd_b", fwd_b, 0);

        // Self-read: ID writes the register it reads, no older producer
        doReset();
        applyStimulus(1, 5'd4, 5'd4, 5'd4, 1, 0); clockEdge();
        checkOutput("self_fwd_a", fwd_a, 0);

        // Invalid ID instruction yields no forward even with a match
        applyStimulus(0, 5'd4, 5'd4, 5'd2, 1, 0); clockEdge();
        checkOutput("invalid_fwd_a", fwd_a, 0);

        // LW r5 ; ADD rs=r5 on both default and DEPTH=3/LOAD_POS=3
        doReset();
        applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 1); clockEdge();
        applyStimulus(1, 5'd5, 5'd2, 5'd7, 1, 0);
        checkOutput("lu_stall_c1", stall, 1);
        checkOutput("lu3_stall_c1", stall3, 1);
        clockEdge();
        checkOutput("lu_bubble_fwd_a", fwd_a, 0);
        checkOutput("lu_count_c1", stall_count, 1);
        checkOutput("lu_stall_c2", stall, 0);
        checkOutput("lu3_stall_c2", stall3, 1);
        clockEdge();
        checkOutput("lu_fwd_a", fwd_a, 2);
        checkOutput("lu_count_c2", stall_count, 1);
        checkOutput("lu3_count_c2", count3, 2);
        checkOutput("lu3_stall_c3", stall3, 0);
        clockEdge();
        checkOutput("lu3_fwd_a", fwdA3, 3);
        checkOutput("lu3_count_c3", count3, 2);

        // Freeze during a load-use stall: ADD r1 ; LW r5 rs=r1 ; ADD rs=r5 frozen 4 cycles
        doReset();
        applyStimulus(1, 5'd2, 5'd0, 5'd1, 1, 0); clockEdge();
        applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 1); clockEdge();
        checkOutput("frz_pre_fwd_a", fwd_a, 1);
        freeze = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 5'd5, 5'd2, 5'd7, 1, 0);
            checkOutput("frz_stall", stall, 1);
            clockEdge();
            checkOutput("frz_count", stall_count, 0);
            checkOutput("frz_fwd_a", fwd_a, 1);
        end
        freeze = 1'b0;
        applyStimulus(1, 5'd5, 5'd2, 5'd7, 1, 0);
        checkOutput("frz_rel_stall", stall, 1);
        clockEdge();
        checkOutput("frz_rel_count", stall_count, 1);
        checkOutput("frz_rel_bubble", fwd_a, 0);
        checkOutput("frz_rel_stall2", stall, 0);
        clockEdge();
        checkOutput("frz_rel_fwd_a", fwd_a, 2);

        // Flush on a hazard cycle
        doReset();
        applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 1); clockEdge();
        flush = 1'b1;
        applyStimulus(1, 5'd5, 5'd2, 5'd7, 1, 0);
        checkOutput("flush_stall", stall, 0);
        clockEdge();
        flush = 1'b0;
        checkOutput("flush_fwd_a", fwd_a, 0);
        checkOutput("flush_count", stall_count, 0);
        applyStimulus(1, 5'd5, 5'd0, 5'd8, 1, 0);
        checkOutput("flush_after_stall", stall, 0);
        clockEdge();
        checkOutput("flush_after_fwd_a", fwd_a, 2);

        // Five load-use stalls: CNT_W=2 saturates at 3
        doReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 1); clockEdge();
            applyStimulus(1, 5'd5, 5'd2, 5'd7, 1, 0); clockEdge();
            clockEdge();
        end
        checkOutput("sat_count_c2", countC, 3);
        checkOutput("sat_count_c16", stall_count, 5);

        // perf_clear together with a stall
        applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 1); clockEdge();
        perf_clear = 1'b1;
        applyStimulus(1, 5'd5, 5'd2, 5'd7, 1, 0);
        checkOutput("clr_stall", stall, 1);
        clockEdge();
        perf_clear = 1'b0;
        checkOutput("clr_count", stall_count, 0);

        // Reset mid-stall drops the stall and records nothing
        applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 1); clockEdge();
        applyStimulus(1, 5'd5, 5'd2, 5'd7, 1, 0);
        checkOutput("rst_mid_pre", stall, 1);
        reset = 1'b1;
        clockEdge();
        checkOutput("rst_mid_stall", stall, 0);
        reset = 1'b0;
        clockEdge();
        checkOutput("rst_mid_fwd_a", fwd_a, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
